// File: rtl/video_sync_timing_gen.sv
// video_sync_timing_gen
//   Raster timing generator on the pixel clock. The horizontal and vertical
//   counters walk sync, back porch, active and front porch. Every output is a
//   registered decode of the counters and lags them by one cycle. When en_i is
//   dropped, the frame in progress always runs to completion.
// Ports
//   clk_pixel_i    pixel clock
//   rst_i          synchronous reset, active high
//   en_i           run request, level sensitive
//   hsync_o        horizontal sync, active high, HSYNC_WIDTH pixel clocks
//   vsync_o        vertical sync, active high, VSYNC_WIDTH whole lines
//   de_o           data enable: active pixel of an active line
//   line_start_o   pulse on the first hsync cycle of every line
//   frame_start_o  pulse on the first hsync cycle of line 0
//   busy_o         high while running or finishing the last frame
module video_sync_timing_gen #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned H_FP        = 40,
  parameter int unsigned HSYNC_WIDTH = 5,
  parameter int unsigned H_BP        = 88,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned V_FP        = 1,
  parameter int unsigned VSYNC_WIDTH = 4,
  parameter int unsigned V_BP        = 23
) (
  input  logic clk_pixel_i,
  input  logic rst_i,
  input  logic en_i,
  output logic hsync_o,
  output logic vsync_o,
  output logic de_o,
  output logic line_start_o,
  output logic frame_start_o,
  output logic busy_o
);

  localparam int unsigned H_TOTAL  = HSYNC_WIDTH + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL  = VSYNC_WIDTH + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned H_DE_BEG = HSYNC_WIDTH + H_BP;
  localparam int unsigned H_DE_END = H_DE_BEG + H_ACTIVE;
  localparam int unsigned V_DE_BEG = VSYNC_WIDTH + V_BP;
  localparam int unsigned V_DE_END = V_DE_BEG + V_ACTIVE;

  if (HSYNC_WIDTH < 1 || HSYNC_WIDTH > 15) begin : g_bad_hsync
    $error("HSYNC_WIDTH must be in 1..15");
  end
  if (VSYNC_WIDTH < 1 || VSYNC_WIDTH > 15) begin : g_bad_vsync
    $error("VSYNC_WIDTH must be in 1..15");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
    $error("H_ACTIVE and V_ACTIVE must be non-zero");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic            hsync_q, vsync_q, de_q, line_start_q, frame_start_q, busy_q;

  logic            h_last, v_last, running;
  logic            hs_w, vs_w, de_w;

  assign h_last  = (h_q == HW'(H_TOTAL - 1));
  assign v_last  = (v_q == VW'(V_TOTAL - 1));
  assign running = (state_q != ST_IDLE);

  // Decodes are compared at 32 bits so a boundary equal to the total still
  // works when the total is an exact power of two.
  assign hs_w = (32'(h_q) < HSYNC_WIDTH);
  assign vs_w = (32'(v_q) < VSYNC_WIDTH);
  assign de_w = (32'(h_q) >= H_DE_BEG) && (32'(h_q) < H_DE_END) &&
                (32'(v_q) >= V_DE_BEG) && (32'(v_q) < V_DE_END);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_i) state_d = ST_RUN;
      ST_RUN:  if (!en_i) state_d = ST_STOP;
      ST_STOP: begin
        if (en_i)                  state_d = ST_RUN;
        else if (h_last && v_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters only advance outside IDLE; the STOP->IDLE exit coincides with
  // the natural wrap, so both counters land on 0 without a separate clear.
  always_comb begin
    h_d = '0;
    v_d = '0;
    if (running) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end
  end

  always_ff @(posedge clk_pixel_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= running && hs_w;
      vsync_q       <= running && vs_w;
      de_q          <= running && de_w;
      line_start_q  <= running && (h_q == '0);
      frame_start_q <= running && (h_q == '0) && (v_q == '0);
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;
  assign de_o          = de_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_video_sync_timing_gen.sv
// tb_video_sync_timing_gen
//   Small-raster instance (28 x 14) plus a default 800x600 instance. Each is
//   compared every cycle against a frame-position model, and targeted
//   measurements cover widths, periods, latency, stop and mid-frame reset.
module tb_video_sync_timing_gen;

  localparam int unsigned S_HT = 28;
  localparam int unsigned S_VT = 14;
  localparam int unsigned S_FRAME = S_HT * S_VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, rst2 = 1'b1, en2 = 1'b0;
  logic hsync_o, vsync_o, de_o, line_start_o, frame_start_o, busy_o;
  logic hs2, vs2, de2, ls2, fs2, busy2;

  video_sync_timing_gen #(
    .H_ACTIVE(16), .H_FP(3), .HSYNC_WIDTH(5), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(2), .VSYNC_WIDTH(4), .V_BP(2)
  ) dut (
    .clk_pixel_i(clk), .rst_i(rst), .en_i(en),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .line_start_o(line_start_o), .frame_start_o(frame_start_o), .busy_o(busy_o)
  );

  video_sync_timing_gen dut2 (
    .clk_pixel_i(clk), .rst_i(rst2), .en_i(en2),
    .hsync_o(hs2), .vsync_o(vs2), .de_o(de2),
    .line_start_o(ls2), .frame_start_o(fs2), .busy_o(busy2)
  );

  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Reference model: raster geometry per instance, position within the frame.
  int unsigned m_ha [2] = '{16, 800};
  int unsigned m_hf [2] = '{3, 40};
  int unsigned m_hs [2] = '{5, 5};
  int unsigned m_hb [2] = '{4, 88};
  int unsigned m_va [2] = '{6, 600};
  int unsigned m_vf [2] = '{2, 1};
  int unsigned m_vs [2] = '{4, 4};
  int unsigned m_vb [2] = '{2, 23};

  int          m_mode [2] = '{0, 0};   // 0 idle, 1 running, 2 finishing frame
  int unsigned m_pos  [2] = '{0, 0};
  logic [5:0]  m_exp  [2] = '{6'd0, 6'd0};

  function automatic logic [4:0] decode(input int i, input int unsigned p);
    int unsigned ht, h, v;
    logic hs, vs, de, ls, fs;
    ht = m_hs[i] + m_hb[i] + m_ha[i] + m_hf[i];
    h  = p % ht;
    v  = p / ht;
    hs = h < m_hs[i];
    vs = v < m_vs[i];
    de = (h >= m_hs[i] + m_hb[i]) && (h < m_hs[i] + m_hb[i] + m_ha[i]) &&
         (v >= m_vs[i] + m_vb[i]) && (v < m_vs[i] + m_vb[i] + m_va[i]);
    ls = (h == 0);
    fs = (p == 0);
    return {hs, vs, de, ls, fs};
  endfunction

  always @(posedge clk) begin : model
    logic r, e;
    int nm;
    int unsigned ft;
    logic [4:0] o;
    for (int i = 0; i < 2; i++) begin
      r  = (i == 0) ? rst : rst2;
      e  = (i == 0) ? en  : en2;
      ft = (m_hs[i] + m_hb[i] + m_ha[i] + m_hf[i]) * (m_vs[i] + m_vb[i] + m_va[i] + m_vf[i]);
      if (r) begin
        m_mode[i] = 0;
        m_pos[i]  = 0;
        m_exp[i]  = '0;
      end else begin
        nm = m_mode[i];
        if (m_mode[i] == 0 && e) nm = 1;
        else if (m_mode[i] == 1 && !e) nm = 2;
        else if (m_mode[i] == 2) nm = e ? 1 : ((m_pos[i] == ft - 1) ? 0 : 2);
        o = (m_mode[i] == 0) ? 5'b0 : decode(i, m_pos[i]);
        m_exp[i] = {o, nm != 0};
        m_pos[i] = (m_mode[i] == 0) ? 0 : (m_pos[i] + 1) % ft;
        m_mode[i] = nm;
      end
    end
  end

  logic chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cycle_small", {hsync_o, vsync_o, de_o, line_start_o, frame_start_o, busy_o}, m_exp[0]);
      chk("cycle_default", {hs2, vs2, de2, ls2, fs2, busy2}, m_exp[1]);
    end
  end

  int hs_cnt, vs_cnt, de_cnt, ls_cnt, fs_cnt, hs_len, vs_len, hs_in_vs;
  int last_rise, n;
  logic p_hs, p_vs, p_de;

  initial begin
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_outputs", {hsync_o, vsync_o, de_o, line_start_o, frame_start_o, busy_o}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_outputs", {hsync_o, vsync_o, de_o, line_start_o, frame_start_o, busy_o}, 0);

    // Start latency, then three uninterrupted frames of width measurements.
    en = 1'b1;
    @(negedge clk);
    chk("lat_hsync_k", hsync_o, 0);
    chk("lat_busy_k", busy_o, 1);
    @(negedge clk);
    chk("lat_hsync_k1", hsync_o, 1);
    chk("lat_fstart_k1", frame_start_o, 1);
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    hs_len = 0; vs_len = 0; hs_in_vs = 0; last_rise = -1;
    p_hs = 0; p_vs = 0; p_de = 0;
    for (int j = 0; j < 3 * S_FRAME; j++) begin
      hs_cnt += int'(hsync_o); vs_cnt += int'(vsync_o); de_cnt += int'(de_o);
      ls_cnt += int'(line_start_o); fs_cnt += int'(frame_start_o);
      if (hsync_o) hs_len++;
      if (vsync_o) vs_len++;
      if (hsync_o && !p_hs) begin
        if (last_rise >= 0) chk("hs_period", j - last_rise, S_HT);
        last_rise = j;
        if (vsync_o) hs_in_vs++;
      end
      if (!hsync_o && p_hs) begin chk("hs_width", hs_len, 5); hs_len = 0; end
      if (!vsync_o && p_vs) begin
        chk("vs_width", vs_len, 112);
        chk("vs_hsyncs", hs_in_vs, 4);
        vs_len = 0; hs_in_vs = 0;
      end
      if (de_o && !p_de) chk("de_offset", j - last_rise, 9);
      p_hs = hsync_o; p_vs = vsync_o; p_de = de_o;
      @(negedge clk);
    end
    chk("hs_total", hs_cnt, 3 * 14 * 5);
    chk("vs_total", vs_cnt, 3 * 112);
    chk("de_total", de_cnt, 3 * 96);
    chk("ls_total", ls_cnt, 3 * 14);
    chk("fs_total", fs_cnt, 3);

    // Graceful stop at line 3: the rest of the frame must still play out.
    repeat (3 * S_HT) @(negedge clk);
    en = 1'b0;
    n = 0;
    while (busy_o && n < 2000) begin @(negedge clk); n++; end
    chk("stop_cycles", n, S_FRAME - (3 * S_HT + 1));
    repeat (50) @(negedge clk);
    chk("stopped_outputs", {hsync_o, vsync_o, de_o, busy_o}, 0);

    // Resume from STOP without a gap: two frame starts in any two-frame window.
    en = 1'b1;
    repeat (5 * S_HT + 1) @(negedge clk);
    en = 1'b0;
    repeat (40) @(negedge clk);
    en = 1'b1;
    fs_cnt = 0;
    for (int j = 0; j < 2 * S_FRAME; j++) begin
      fs_cnt += int'(frame_start_o);
      @(negedge clk);
    end
    chk("resume_fstarts", fs_cnt, 2);

    // Mid-frame reset during vsync, en held high throughout.
    n = 0;
    while (!vsync_o && n < 2 * S_FRAME) begin @(negedge clk); n++; end
    chk("found_vsync", vsync_o, 1);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", {hsync_o, vsync_o, de_o, line_start_o, frame_start_o, busy_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_hsync1", hsync_o, 0);
    @(negedge clk);
    chk("rst_rel_hsync2", hsync_o, 1);
    chk("rst_rel_fstart2", frame_start_o, 1);
    repeat (S_FRAME) @(negedge clk);

    // Random en toggling and occasional reset pulses.
    for (int j = 0; j < 15000; j++) begin
      if ($urandom_range(0, 199) == 0) en = ~en;
      rst = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    rst = 1'b0;

    // Default 800x600 raster: a few lines covering the vsync pulse.
    rst2 = 1'b0;
    @(negedge clk);
    en2 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("def_first_hsync", hs2, 1);
    hs_cnt = 0; vs_cnt = 0; hs_len = 0; last_rise = -1; p_hs = 0;
    for (int j = 0; j < 6 * 933; j++) begin
      hs_cnt += int'(hs2); vs_cnt += int'(vs2);
      if (hs2) hs_len++;
      if (hs2 && !p_hs) begin
        if (last_rise >= 0) chk("def_hs_period", j - last_rise, 933);
        last_rise = j;
      end
      if (!hs2 && p_hs) begin chk("def_hs_width", hs_len, 5); hs_len = 0; end
      p_hs = hs2;
      @(negedge clk);
    end
    chk("def_vs_cycles", vs_cnt, 4 * 933);
    chk("def_hs_cycles", hs_cnt, 6 * 5);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
